// File: rtl/uart_tx_tick_pkg.sv
// Shared definitions for the tick-paced UART transmitter: parity modes,
// FSM state encoding and the parity helper.
package uart_tx_tick_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_START,
        ST_DATA,
        ST_PAR,
        ST_STOP
    } state_e;

    // data_xor is the reduction XOR of the word; even parity is that XOR, odd its inverse.
    function automatic logic parity_bit(input int mode, input logic data_xor);
        return (mode == PARITY_ODD) ? ~data_xor : data_xor;
    endfunction

endpackage

// File: rtl/uart_tx_tick.sv
// UART transmitter paced by an external one-cycle baud enable. Accepts a word on
// Valid/Ready and shifts it out LSB-first: start, data, optional parity, stop bits.
module uart_tx_tick
    import uart_tx_tick_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 BaudTick,
    input  logic [DATA_BITS-1:0] Data,
    input  logic                 Valid,
    output logic                 Ready,
    output logic                 Tx,
    output logic                 Busy
);

    localparam int                 CNT_W     = $clog2(DATA_BITS) + 1;
    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(DATA_BITS - 1);
    localparam logic               STOP_LAST = (STOP_BITS == 2);

    generate
        if (DATA_BITS < 5 || DATA_BITS > 9 ||
            PARITY < PARITY_NONE || PARITY > PARITY_EVEN ||
            (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_bad_params
            $error("uart_tx_tick: illegal DATA_BITS/PARITY/STOP_BITS");
        end
    endgenerate

    state_e                 state_q, state_d;
    logic [DATA_BITS-1:0]   shreg_q, shreg_d;
    logic                   par_q,   par_d;
    logic [CNT_W-1:0]       cnt_q,   cnt_d;
    logic                   stop_q,  stop_d;
    logic                   tx_q,    tx_d;
    logic                   ready_q, ready_d;
    logic                   busy_q,  busy_d;

    // NOTE: every next-state signal takes its current value first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        cnt_d   = cnt_q;
        stop_d  = stop_q;
        tx_d    = tx_q;
        ready_d = ready_q;
        busy_d  = busy_q;

        case (state_q)
            ST_IDLE: begin
                // A tick in the accept cycle is deliberately not looked at here.
                if (Valid && ready_q) begin
                    shreg_d = Data;
                    par_d   = parity_bit(PARITY, ^Data);
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                    state_d = ST_SYNC;
                end
            end
            ST_SYNC: begin
                if (BaudTick) begin
                    tx_d    = 1'b0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (BaudTick) begin
                    tx_d    = shreg_q[0];
                    shreg_d = shreg_q >> 1;
                    cnt_d   = '0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (BaudTick) begin
                    if (cnt_q < CNT_LAST) begin
                        cnt_d   = cnt_q + 1'b1;
                        tx_d    = shreg_q[0];
                        shreg_d = shreg_q >> 1;
                    end else if (PARITY != PARITY_NONE) begin
                        tx_d    = par_q;
                        state_d = ST_PAR;
                    end else begin
                        tx_d    = 1'b1;
                        stop_d  = 1'b0;
                        state_d = ST_STOP;
                    end
                end
            end
            ST_PAR: begin
                if (BaudTick) begin
                    tx_d    = 1'b1;
                    stop_d  = 1'b0;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (BaudTick) begin
                    if (stop_q == STOP_LAST) begin
                        busy_d  = 1'b0;
                        ready_d = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        stop_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of process evaluation order.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            par_q   <= 1'b0;
            cnt_q   <= '0;
            stop_q  <= 1'b0;
            tx_q    <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            cnt_q   <= cnt_d;
            stop_q  <= stop_d;
            tx_q    <= tx_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    assign Ready = ready_q;
    assign Tx    = tx_q;
    assign Busy  = busy_q;

endmodule

// File: tb/tb_uart_tx_tick.sv
// Scoreboard bench for uart_tx_tick: four instances (8N1, 8E1, 8O1, 7N2) driven by
// directed words; a monitor pops the expected line level at every baud-tick update.
module tb_uart_tx_tick;

    typedef struct packed {
        logic tx;
        logic busy;
    } exp_t;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       baud16;
    logic [7:0] data_v [3];
    logic [6:0] data7;
    logic       valid_v [4];
    logic       ready_v [4];
    logic       tx_v    [4];
    logic       busy_v  [4];

    exp_t exp_q [4][$];
    int   fire_cnt [4];
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 Clk = ~Clk;

    int div_cnt = 0;
    always @(posedge Clk) begin
        #1;
        baud16  = (div_cnt == 15);
        div_cnt = (div_cnt + 1) % 16;
    end

    uart_tx_tick #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_8n1 (
        .Clk(Clk), .Reset(Reset), .BaudTick(baud16), .Data(data_v[0]), .Valid(valid_v[0]),
        .Ready(ready_v[0]), .Tx(tx_v[0]), .Busy(busy_v[0]));
    uart_tx_tick #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut_8e1 (
        .Clk(Clk), .Reset(Reset), .BaudTick(baud16), .Data(data_v[1]), .Valid(valid_v[1]),
        .Ready(ready_v[1]), .Tx(tx_v[1]), .Busy(busy_v[1]));
    uart_tx_tick #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) dut_8o1 (
        .Clk(Clk), .Reset(Reset), .BaudTick(baud16), .Data(data_v[2]), .Valid(valid_v[2]),
        .Ready(ready_v[2]), .Tx(tx_v[2]), .Busy(busy_v[2]));
    uart_tx_tick #(.DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) dut_7n2 (
        .Clk(Clk), .Reset(Reset), .BaudTick(1'b1), .Data(data7), .Valid(valid_v[3]),
        .Ready(ready_v[3]), .Tx(tx_v[3]), .Busy(busy_v[3]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Queue the hand-written line levels of one frame ('0'/'1', start bit first);
    // the tick that ends the last stop bit must leave Tx high and Busy low.
    task automatic expect_bits(input int i, input string bits);
        for (int k = 0; k < bits.len(); k++)
            exp_q[i].push_back('{tx: (bits[k] == "1"), busy: 1'b1});
        exp_q[i].push_back('{tx: 1'b1, busy: 1'b0});
    endtask

    // Monitor: a tick seen with Busy high is an edge where Tx takes its next level;
    // on every other edge Tx must hold.
    logic fire    [4];
    logic tx_prev [4];
    logic rst_prev = 1'b0;
    exp_t e_mon;

    initial for (int i = 0; i < 4; i++) begin
        fire[i]     = 1'b0;
        tx_prev[i]  = 1'b1;
        fire_cnt[i] = 0;
    end

    always @(negedge Clk) begin
        for (int i = 0; i < 4; i++) begin
            if (Reset && rst_prev) begin
                if (fire[i]) begin
                    check($sformatf("dut%0d expected bit queued", i), exp_q[i].size() > 0, 1);
                    if (exp_q[i].size() > 0) begin
                        e_mon = exp_q[i].pop_front();
                        check($sformatf("dut%0d tx bit %0d", i, fire_cnt[i]), tx_v[i], e_mon.tx);
                        check($sformatf("dut%0d busy bit %0d", i, fire_cnt[i]), busy_v[i], e_mon.busy);
                    end
                    fire_cnt[i]++;
                end else begin
                    check($sformatf("dut%0d tx hold", i), tx_v[i], tx_prev[i]);
                end
            end
            tx_prev[i] = tx_v[i];
            fire[i]    = Reset && busy_v[i] && ((i == 3) ? 1'b1 : baud16);
        end
        rst_prev = Reset;
    end

    task automatic drive(input int i, input logic [7:0] d, input logic v);
        if (i == 3) data7 = d[6:0];
        else        data_v[i] = d;
        valid_v[i] = v;
    endtask

    task automatic send(input int i, input logic [7:0] d, input bit keep);
        int n = 0;
        @(posedge Clk); #3;
        drive(i, d, 1'b1);
        @(negedge Clk);
        while (!ready_v[i] && n < 4000) begin
            @(negedge Clk);
            n++;
        end
        check($sformatf("dut%0d ready before accept", i), ready_v[i], 1);
        check($sformatf("dut%0d idle at accept", i), busy_v[i], 0);
        @(posedge Clk); #3;
        if (!keep) valid_v[i] = 1'b0;
        check($sformatf("dut%0d ready after accept", i), ready_v[i], 0);
        check($sformatf("dut%0d busy after accept", i), busy_v[i], 1);
    endtask

    task automatic wait_done(input int i);
        int n = 0;
        while (exp_q[i].size() != 0 && n < 4000) begin
            @(negedge Clk);
            n++;
        end
        check($sformatf("dut%0d frame complete", i), exp_q[i].size(), 0);
        @(negedge Clk);
        check($sformatf("dut%0d ready at end", i), ready_v[i], 1);
        check($sformatf("dut%0d busy at end", i), busy_v[i], 0);
        check($sformatf("dut%0d tx idle at end", i), tx_v[i], 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int base;
        baud16 = 1'b0;
        Reset  = 1'b0;
        data7  = '0;
        for (int i = 0; i < 4; i++) begin
            valid_v[i] = 1'b0;
            if (i < 3) data_v[i] = '0;
        end
        #23;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("dut%0d reset tx", i), tx_v[i], 1);
            check($sformatf("dut%0d reset ready", i), ready_v[i], 1);
            check($sformatf("dut%0d reset busy", i), busy_v[i], 0);
        end
        Reset = 1'b1;
        repeat (3) @(negedge Clk);

        // 8N1 0xA5: start, 1,0,1,0,0,1,0,1, stop
        expect_bits(0, "0101001011");
        send(0, 8'hA5, 1'b0);
        wait_done(0);

        // 8E1 / 8O1 0xA5 (four ones): even parity 0, odd parity 1
        expect_bits(1, "01010010101");
        send(1, 8'hA5, 1'b0);
        wait_done(1);
        expect_bits(2, "01010010111");
        send(2, 8'hA5, 1'b0);
        wait_done(2);

        // Back-to-back with Valid held: 0x00 then 0xFF
        expect_bits(0, "0000000001");
        expect_bits(0, "0111111111");
        send(0, 8'h00, 1'b1);
        send(0, 8'hFF, 1'b0);
        wait_done(0);
        wait_done(0);

        // 7N2 with BaudTick tied high, 0x55: one bit per clock
        expect_bits(3, "0101010111");
        send(3, 8'h55, 1'b0);
        wait_done(3);

        // Reset during data bit 3 of 0x00, then 0x3C
        base = fire_cnt[0];
        expect_bits(0, "0000000001");
        send(0, 8'h00, 1'b0);
        n = 0;
        while (fire_cnt[0] < base + 5 && n < 4000) begin
            @(negedge Clk);
            n++;
        end
        check("dut0 reached data bit 3", fire_cnt[0], base + 5);
        check("dut0 tx low in data bit 3", tx_v[0], 0);
        #2 Reset = 1'b0;
        #1;
        check("dut0 async reset tx", tx_v[0], 1);
        check("dut0 async reset ready", ready_v[0], 1);
        check("dut0 async reset busy", busy_v[0], 0);
        exp_q[0].delete();
        @(negedge Clk);
        #2 Reset = 1'b1;
        repeat (2) @(negedge Clk);
        expect_bits(0, "0001111001");
        send(0, 8'h3C, 1'b0);
        wait_done(0);

        // Accept coincident with a tick: no start bit until the following tick
        n = 0;
        do begin
            @(posedge Clk); #3;
            n++;
        end while (!baud16 && n < 64);
        check("tick alignment found", baud16, 1);
        expect_bits(0, "0100000011");
        drive(0, 8'h81, 1'b1);
        @(posedge Clk); #3;
        valid_v[0] = 1'b0;
        check("coincident accept busy", busy_v[0], 1);
        check("coincident accept tx", tx_v[0], 1);
        repeat (8) begin
            @(negedge Clk);
            check("no early start bit", tx_v[0], 1);
        end
        wait_done(0);

        repeat (4) @(negedge Clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
